lc3_pipe_controller: RTL and testbench

- Central controller for the LC3 five-stage pipeline: fetch, decode, execute, writeback and memory access.
- Generates the per-stage enables that the decode and execute stages receive as enable_decode/enable_execute.
- Generates the execute-stage bypass selects (bypass_alu_1/2, bypass_mem_1/2) and the memory-access state sequence.
- Inserts stalls and bubbles for loads, stores, indirect accesses, branches and instruction-memory wait.

---
 rtl/lc3_ctrl_pkg.sv | 50 +++++
 rtl/lc3_pipe_controller_mem_fsm.sv | 48 ++++
 rtl/lc3_pipe_controller.sv | 102 ++++++++++
 tb/tb_lc3_pipe_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Opcode constants, memory-access state encoding and instruction-class helpers
// shared by the LC3 pipeline controller.
package lc3_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_IND  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_IDLE = 2'd3
  } mem_state_e;

  function automatic logic is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_ST, OP_STR, OP_STI};
  endfunction

  function automatic logic is_ctrl(input logic [3:0] op);
    return op inside {OP_BR, OP_JMP};
  endfunction

  function automatic logic uses_sr1(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP};
  endfunction

  // Register-form ADD/AND only; the immediate form has no SR2.
  function automatic logic uses_sr2(input logic [15:0] ir);
    return (ir[15:12] == OP_ADD || ir[15:12] == OP_AND) && !ir[5];
  endfunction

endpackage

// File: rtl/lc3_pipe_controller_mem_fsm.sv
// Data-memory access sequencer: walks read/indirect/write phases for the
// instruction in execute and stalls the front of the pipe while busy.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       exe_valid,
  input  logic [3:0] op,
  input  logic       complete_data,
  output mem_state_e mem_state,
  output logic       stall
);

  mem_state_e state_q, state_d;
  logic       ind_wr_q, ind_wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MEM_IDLE;
      ind_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ind_wr_q <= ind_wr_d;
    end
  end

  // The indirect phase fetches a pointer; ind_wr remembers whether it feeds a store.
  always_comb begin
    state_d  = state_q;
    ind_wr_d = ind_wr_q;
    case (state_q)
      MEM_IDLE:
        if (exe_valid && (is_load(op) || is_store(op))) begin
          ind_wr_d = (op == OP_STI);
          if (op == OP_LDI || op == OP_STI) state_d = MEM_IND;
          else if (is_load(op))             state_d = MEM_RD;
          else                              state_d = MEM_WR;
        end
      MEM_IND: if (complete_data) state_d = ind_wr_q ? MEM_WR : MEM_RD;
      default: if (complete_data) state_d = MEM_IDLE;
    endcase
  end

  assign mem_state = state_q;
  assign stall     = (state_q != MEM_IDLE);

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC3 five-stage pipeline controller: stage enables, operand bypass selects,
// branch shadow bubbles and memory-access stalls.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int OPW       = 4,
  parameter int BR_SHADOW = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IMem_dout,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  localparam int SHW = $clog2(BR_SHADOW + 1);

  logic           run_q, v_dec, v_exe, v_wb;
  logic [SHW-1:0] shadow_q;
  mem_state_e     mem_st;
  logic           mem_stall;
  logic [OPW-1:0] op_f, op_d, op_e;
  logic [2:0]     dst_e;
  logic           sr1_hit, sr2_hit, br_cond, mem_rd;
  logic           unused_bits;

  assign op_f  = IMem_dout[15 -: OPW];
  assign op_d  = IR[15 -: OPW];
  assign op_e  = IR_Exec[15 -: OPW];
  assign dst_e = IR_Exec[11:9];
  assign unused_bits = ^{IMem_dout[11:0], IR[4:3], IR_Exec[8:0]};

  lc3_mem_fsm u_mem_fsm (
    .clk           (clk),
    .rst_n         (reset),
    .exe_valid     (v_exe),
    .op            (op_e),
    .complete_data (complete_data),
    .mem_state     (mem_st),
    .stall         (mem_stall)
  );

  assign mem_state = mem_st;
  assign mem_rd    = (mem_st == MEM_RD);

  assign enable_fetch     = run_q & ~mem_stall & complete_instr & (shadow_q == '0);
  assign enable_decode    = v_dec & ~mem_stall & complete_instr;
  assign enable_execute   = v_exe & ~mem_stall;
  assign enable_writeback = mem_stall ? (mem_rd & complete_data) : v_wb;

  // Branch resolves only when execute advances, so a memory stall defers it.
  assign br_cond         = (op_e == OP_JMP) | (|(dst_e & psr));
  assign br_taken        = enable_execute & is_ctrl(op_e) & br_cond;
  assign enable_updatePC = enable_fetch | br_taken;

  assign sr1_hit = uses_sr1(op_d) && (dst_e == IR[8:6]);
  assign sr2_hit = (uses_sr2(IR) && (dst_e == IR[2:0])) ||
                   (is_store(op_d) && (dst_e == IR[11:9]));

  assign bypass_alu_1 = v_exe & is_alu(op_e) & sr1_hit;
  assign bypass_alu_2 = v_exe & is_alu(op_e) & sr2_hit;
  assign bypass_mem_1 = v_exe & is_load(op_e) & mem_rd & sr1_hit;
  assign bypass_mem_2 = v_exe & is_load(op_e) & mem_rd & sr2_hit;

  // Valid bits freeze under a memory stall; an instruction wait holds v_dec
  // and lets a bubble flow into execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      v_dec    <= 1'b0;
      v_exe    <= 1'b0;
      v_wb     <= 1'b0;
      shadow_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (!mem_stall) begin
        v_wb  <= v_exe;
        v_exe <= enable_decode;
        if (complete_instr) v_dec <= enable_fetch;
        if (enable_fetch && is_ctrl(op_f))
          shadow_q <= SHW'(BR_SHADOW);
        else if (shadow_q != '0 && complete_instr)
          shadow_q <= shadow_q - SHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for lc3_pipe_controller: a cycle-level behavioural model
// checked every cycle plus hand-computed expectations at key points.
module tb_lc3_pipe_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        complete_instr = 1'b1;
  logic        complete_data = 1'b0;
  logic [15:0] IMem_dout = 16'h1283;
  logic [15:0] IR = 16'h1283;
  logic [15:0] IR_Exec = 16'h1283;
  logic [2:0]  psr = 3'b000;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute;
  logic        enable_writeback, br_taken;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;

  int n_checks = 0;
  int n_err = 0;
  bit cmp_on = 0;

  localparam int BR_SHADOW = 3;

  lc3_pipe_controller dut (
    .clk              (clk),
    .reset            (reset),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .IMem_dout        (IMem_dout),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2),
    .bypass_mem_1     (bypass_mem_1),
    .bypass_mem_2     (bypass_mem_2),
    .mem_state        (mem_state)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: run flag, valid per stage (0=dec,1=exe,2=wb), shadow count,
  // and the list of memory phases still to perform.
  int m_run, m_sh;
  int mv[3];
  int mq[$];
  int e_fetch, e_dec, e_exe, e_wb, e_br, e_upc, e_ba1, e_ba2, e_bm1, e_bm2, e_ms;

  function automatic int cls(input int op);
    case (op)
      1, 5, 9, 14: return 1;  // alu
      2, 6, 10:    return 2;  // load
      3, 7, 11:    return 3;  // store
      0, 12:       return 4;  // control
      default:     return 0;
    endcase
  endfunction

  task automatic calc();
    int xop, dop, s1, s2, stall;
    stall = (mq.size() > 0);
    e_ms  = stall ? mq[0] : 3;
    xop = int'(IR_Exec[15:12]);
    dop = int'(IR[15:12]);
    e_fetch = int'(m_run != 0 && !stall && complete_instr && m_sh == 0);
    e_dec   = int'(mv[0] != 0 && !stall && complete_instr);
    e_exe   = int'(mv[1] != 0 && !stall);
    e_wb    = stall ? int'(e_ms == 0 && complete_data) : mv[2];
    e_br    = int'(e_exe != 0 && cls(xop) == 4 && (xop == 12 || (IR_Exec[11:9] & psr) != 3'b000));
    e_upc   = int'(e_fetch != 0 || e_br != 0);
    s1 = int'((dop inside {1, 5, 9, 6, 7, 12}) && IR_Exec[11:9] == IR[8:6]);
    s2 = int'(((dop == 1 || dop == 5) && !IR[5] && IR_Exec[11:9] == IR[2:0]) ||
              (cls(dop) == 3 && IR_Exec[11:9] == IR[11:9]));
    e_ba1 = int'(mv[1] != 0 && cls(xop) == 1 && s1 != 0);
    e_ba2 = int'(mv[1] != 0 && cls(xop) == 1 && s2 != 0);
    e_bm1 = int'(mv[1] != 0 && cls(xop) == 2 && e_ms == 0 && s1 != 0);
    e_bm2 = int'(mv[1] != 0 && cls(xop) == 2 && e_ms == 0 && s2 != 0);
  endtask

  // Inputs change only just after posedge, so values seen at negedge are the
  // ones the next posedge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        int n0, n1, n2;
        if (!reset) begin
          m_run = 0; m_sh = 0; mv = '{0, 0, 0}; mq.delete();
        end
        calc();
        cmp("m_enable_fetch",     enable_fetch,     e_fetch);
        cmp("m_enable_updatePC",  enable_updatePC,  e_upc);
        cmp("m_enable_decode",    enable_decode,    e_dec);
        cmp("m_enable_execute",   enable_execute,   e_exe);
        cmp("m_enable_writeback", enable_writeback, e_wb);
        cmp("m_br_taken",         br_taken,         e_br);
        cmp("m_bypass_alu_1",     bypass_alu_1,     e_ba1);
        cmp("m_bypass_alu_2",     bypass_alu_2,     e_ba2);
        cmp("m_bypass_mem_1",     bypass_mem_1,     e_bm1);
        cmp("m_bypass_mem_2",     bypass_mem_2,     e_bm2);
        cmp("m_mem_state",        mem_state,        e_ms);
        if (reset) begin
          if (mq.size() > 0) begin
            if (complete_data) void'(mq.pop_front());
          end else begin
            if (mv[1] != 0)
              case (int'(IR_Exec[15:12]))
                2, 6: mq.push_back(0);
                10:   begin mq.push_back(1); mq.push_back(0); end
                3, 7: mq.push_back(2);
                11:   begin mq.push_back(1); mq.push_back(2); end
                default: ;
              endcase
            n2 = mv[1];
            n1 = e_dec;
            n0 = complete_instr ? e_fetch : mv[0];
            mv = '{n0, n1, n2};
            if (e_fetch != 0 && cls(int'(IMem_dout[15:12])) == 4) m_sh = BR_SHADOW;
            else if (m_sh > 0 && complete_instr) m_sh--;
          end
          m_run = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b0;
    cmp_on = 1;
    tick(); tick();
    reset = 1'b1;
    at_neg();
    cmp("start_fetch_c0", enable_fetch, 0);
    cmp("start_ms_c0", mem_state, 3);
    tick(); at_neg();
    cmp("start_fetch_c1", enable_fetch, 1);
    cmp("start_upc_c1", enable_updatePC, 1);
    cmp("start_dec_c1", enable_decode, 0);
    tick(); at_neg();
    cmp("start_dec_c2", enable_decode, 1);
    cmp("start_exe_c2", enable_execute, 0);
    tick(); at_neg();
    cmp("start_exe_c3", enable_execute, 1);
    cmp("start_wb_c3", enable_writeback, 0);
    tick(); at_neg();
    cmp("start_wb_c4", enable_writeback, 1);
    cmp("start_ms_c4", mem_state, 3);

    // ALU forwarding
    tick(); IR = 16'h1845; at_neg();
    cmp("byp_alu1_add", bypass_alu_1, 1);
    cmp("byp_alu2_add", bypass_alu_2, 0);
    tick(); IR = 16'h1841; at_neg();
    cmp("byp_alu1_both", bypass_alu_1, 1);
    cmp("byp_alu2_both", bypass_alu_2, 1);
    tick(); IR = 16'h3200; at_neg();
    cmp("byp_alu1_st", bypass_alu_1, 0);
    cmp("byp_alu2_st", bypass_alu_2, 1);
    tick(); IR = 16'h1283;

    // LDI: 3,1,0,3
    tick(); IR_Exec = 16'hA405; at_neg();
    cmp("ldi_ms_idle", mem_state, 3);
    cmp("ldi_exe_idle", enable_execute, 1);
    tick(); IR_Exec = 16'h1283; at_neg();
    cmp("ldi_ms_ind", mem_state, 1);
    cmp("ldi_fetch_ind", enable_fetch, 0);
    cmp("ldi_dec_ind", enable_decode, 0);
    cmp("ldi_exe_ind", enable_execute, 0);
    tick(); complete_data = 1'b1; at_neg();
    cmp("ldi_ms_ind2", mem_state, 1);
    cmp("ldi_wb_ind", enable_writeback, 0);
    tick(); complete_data = 1'b0; IR_Exec = 16'h2405; IR = 16'h18A5; at_neg();
    cmp("ldi_ms_rd", mem_state, 0);
    cmp("ldi_wb_rd_wait", enable_writeback, 0);
    cmp("byp_mem1_rd", bypass_mem_1, 1);
    cmp("byp_alu1_rd", bypass_alu_1, 0);
    tick(); complete_data = 1'b1; IR_Exec = 16'h1283; IR = 16'h1283; at_neg();
    cmp("ldi_ms_rd2", mem_state, 0);
    cmp("ldi_wb_rd_done", enable_writeback, 1);
    cmp("ldi_exe_rd", enable_execute, 0);
    tick(); complete_data = 1'b0; at_neg();
    cmp("ldi_ms_back", mem_state, 3);
    cmp("ldi_fetch_back", enable_fetch, 1);

    // STI: 3,1,2,3 without writeback
    tick(); IR_Exec = 16'hB203; at_neg();
    cmp("sti_ms_idle", mem_state, 3);
    tick(); IR_Exec = 16'h1283; at_neg();
    cmp("sti_ms_ind", mem_state, 1);
    cmp("sti_wb_ind", enable_writeback, 0);
    tick(); complete_data = 1'b1; at_neg();
    cmp("sti_wb_ind2", enable_writeback, 0);
    tick(); complete_data = 1'b0; at_neg();
    cmp("sti_ms_wr", mem_state, 2);
    tick(); complete_data = 1'b1; at_neg();
    cmp("sti_ms_wr2", mem_state, 2);
    cmp("sti_wb_wr", enable_writeback, 0);
    tick(); complete_data = 1'b0; at_neg();
    cmp("sti_ms_back", mem_state, 3);

    // instruction-memory wait
    tick(); complete_instr = 1'b0; at_neg();
    cmp("iw_fetch", enable_fetch, 0);
    cmp("iw_dec", enable_decode, 0);
    cmp("iw_exe_drain", enable_execute, 1);
    tick(); at_neg();
    cmp("iw_exe_bubble", enable_execute, 0);
    tick(); complete_instr = 1'b1; at_neg();
    cmp("iw_fetch_back", enable_fetch, 1);
    tick(); tick(); tick();

    // BRz: shadow of 3, then resolves in execute
    tick(); IMem_dout = 16'h0403; at_neg();
    cmp("br_fetch", enable_fetch, 1);
    tick(); IMem_dout = 16'h1283; at_neg();
    cmp("br_shadow1", enable_fetch, 0);
    cmp("br_shadow1_upc", enable_updatePC, 0);
    tick(); IR_Exec = 16'h0403; psr = 3'b010; at_neg();
    cmp("br_shadow2", enable_fetch, 0);
    cmp("br_taken_z", br_taken, 1);
    cmp("br_upc_forced", enable_updatePC, 1);
    tick(); IR_Exec = 16'h1283; at_neg();
    cmp("br_shadow3", enable_fetch, 0);
    cmp("br_pulse_end", br_taken, 0);
    cmp("br_upc_end", enable_updatePC, 0);
    tick(); at_neg();
    cmp("br_fetch_resume", enable_fetch, 1);
    tick(); tick(); tick();
    tick(); IR_Exec = 16'h0403; psr = 3'b100; at_neg();
    cmp("br_not_taken", br_taken, 0);
    tick(); IR_Exec = 16'hC080; at_neg();
    cmp("jmp_taken", br_taken, 1);
    tick(); IR_Exec = 16'h1283; psr = 3'b000;

    // asynchronous reset in the middle of an LDI
    tick(); IR_Exec = 16'hA405;
    tick(); IR_Exec = 16'h1283; at_neg();
    cmp("rst_pre_ms", mem_state, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    cmp("rst_ms", mem_state, 3);
    cmp("rst_fetch", enable_fetch, 0);
    cmp("rst_upc", enable_updatePC, 0);
    cmp("rst_dec", enable_decode, 0);
    cmp("rst_exe", enable_execute, 0);
    cmp("rst_wb", enable_writeback, 0);
    cmp("rst_br", br_taken, 0);
    cmp("rst_byp", {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}, 0);
    tick(); tick();
    reset = 1'b1;
    repeat (6) tick();
    at_neg();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
